psm_ctrl: RTL and testbench

PSM_CTRL -- requirements
Module: psm_ctrl

---
 rtl/psm_ctrl.sv | 130 +++++++++++++
 tb/tb_psm_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psm_ctrl.sv
// Power-sequence controller: PSM reset sequencing with a nested PS2
// transfer FSM, ack timeout detection and a saturating error counter.
module psm_ctrl #(
  parameter int unsigned RST_CYCLES  = 4,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_req,
  input  logic       stop_req,
  input  logic       xfer_req,
  input  logic       xfer_ack,
  output logic [2:0] sm_psm,
  output logic [2:0] sm_ps2,
  output logic       rst_out,
  output logic       xfer_busy,
  output logic       timeout_err,
  output logic [7:0] err_cnt
);

  typedef enum logic [2:0] {
    PSM_IDL = 3'd0,
    PSM_RST = 3'd6,
    PSM_ZOT = 3'd7
  } psm_t;

  typedef enum logic [2:0] {
    PS2_IDL = 3'd0,
    PS2_FOO = 3'd1
  } ps2_t;

  localparam logic [7:0] RST_LAST = 8'(RST_CYCLES - 1);
  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  psm_t       psm_q, psm_d;
  ps2_t       ps2_q, ps2_d;
  logic [7:0] rcnt_q, rcnt_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic [7:0] err_q, err_d;
  logic       pend_q, pend_d;
  logic       tmo_q, tmo_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      psm_q  <= PSM_IDL;
      ps2_q  <= PS2_IDL;
      rcnt_q <= '0;
      wcnt_q <= '0;
      err_q  <= '0;
      pend_q <= 1'b0;
      tmo_q  <= 1'b0;
    end else begin
      psm_q  <= psm_d;
      ps2_q  <= ps2_d;
      rcnt_q <= rcnt_d;
      wcnt_q <= wcnt_d;
      err_q  <= err_d;
      pend_q <= pend_d;
      tmo_q  <= tmo_d;
    end
  end

  always_comb begin
    psm_d  = psm_q;
    ps2_d  = ps2_q;
    rcnt_d = rcnt_q;
    wcnt_d = wcnt_q;
    err_d  = err_q;
    pend_d = pend_q;
    tmo_d  = 1'b0;

    unique case (1'b1)
      (psm_q == PSM_IDL): begin
        if (start_req) begin
          psm_d  = PSM_RST;
          rcnt_d = '0;
        end
      end
      (psm_q == PSM_RST): begin
        if (stop_req) begin
          psm_d = PSM_IDL;
        end else if (rcnt_q == RST_LAST) begin
          psm_d = PSM_ZOT;
        end else begin
          rcnt_d = rcnt_q + 8'd1;
        end
      end
      (psm_q == PSM_ZOT): begin
        // A stop during a transfer is held until PS2 drains to idle
        if (ps2_q == PS2_IDL && (stop_req || pend_q)) begin
          psm_d  = PSM_IDL;
          pend_d = 1'b0;
        end else if (ps2_q == PS2_FOO && stop_req) begin
          pend_d = 1'b1;
        end
      end
      default: psm_d = PSM_IDL;
    endcase

    unique case (1'b1)
      (ps2_q == PS2_IDL): begin
        if (psm_q == PSM_ZOT && xfer_req &&
            !stop_req && !pend_q) begin
          ps2_d  = PS2_FOO;
          wcnt_d = '0;
        end
      end
      (ps2_q == PS2_FOO): begin
        if (xfer_ack) begin
          ps2_d = PS2_IDL;
        end else if (wcnt_q == TMO_LAST) begin
          ps2_d = PS2_IDL;
          tmo_d = 1'b1;
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      default: ps2_d = PS2_IDL;
    endcase
  end

  assign sm_psm      = psm_q;
  assign sm_ps2      = ps2_q;
  assign rst_out     = (psm_q == PSM_RST);
  assign xfer_busy   = (ps2_q == PS2_FOO);
  assign timeout_err = tmo_q;
  assign err_cnt     = err_q;

endmodule

// File: tb/tb_psm_ctrl.sv
// Directed self-checking bench for psm_ctrl
// (RST_CYCLES=4, ACK_TIMEOUT=15).
module tb_psm_ctrl;

  logic       clk = 1'b0;
  logic       reset, start_req, stop_req;
  logic       xfer_req, xfer_ack;
  logic [2:0] sm_psm, sm_ps2;
  logic       rst_out, xfer_busy, timeout_err;
  logic [7:0] err_cnt;

  int n_chk = 0;
  int n_fail = 0;

  psm_ctrl #(.RST_CYCLES(4), .ACK_TIMEOUT(15)) dut (
    .clk(clk),
    .reset(reset),
    .start_req(start_req),
    .stop_req(stop_req),
    .xfer_req(xfer_req),
    .xfer_ack(xfer_ack),
    .sm_psm(sm_psm),
    .sm_ps2(sm_ps2),
    .rst_out(rst_out),
    .xfer_busy(xfer_busy),
    .timeout_err(timeout_err),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_zot();
    reset = 1'b1;
    step();
    reset = 1'b0;
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_chk++;
    if (sm_psm !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_psm got %0d exp 0", sm_psm);
    end
    n_chk++;
    if (sm_ps2 !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_ps2 got %0d exp 0", sm_ps2);
    end
    n_chk++;
    if ({rst_out, xfer_busy, timeout_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags got %b exp 000",
               {rst_out, xfer_busy, timeout_err});
    end
    n_chk++;
    if (err_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_err got %0d exp 0", err_cnt);
    end
    // stop in idle is ignored
    stop_req = 1'b1;
    step();
    stop_req = 1'b0;
    n_chk++;
    if (sm_psm !== 3'd0) begin
      n_fail++;
      $display("FAIL idle_stop got %0d exp 0", sm_psm);
    end
  endtask

  task automatic test_sequence();
    start_req = 1'b1;
    step();
    for (int c = 1; c <= 4; c++) begin
      start_req = (c == 2);
      n_chk++;
      if (sm_psm !== 3'd6 || rst_out !== 1'b1) begin
        n_fail++;
        $display("FAIL seq_rst c%0d got psm=%0d rst=%b exp 6/1",
                 c, sm_psm, rst_out);
      end
      step();
    end
    start_req = 1'b0;
    n_chk++;
    if (sm_psm !== 3'd7 || rst_out !== 1'b0) begin
      n_fail++;
      $display("FAIL seq_zot got psm=%0d rst=%b exp 7/0",
               sm_psm, rst_out);
    end
  endtask

  task automatic test_transfer();
    int tmo_seen = 0;
    goto_zot();
    xfer_req = 1'b1;
    step();
    xfer_req = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      tmo_seen += int'(timeout_err);
      n_chk++;
      if (sm_ps2 !== 3'd1 || xfer_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL xfer_busy c%0d got %0d/%b exp 1/1",
                 c, sm_ps2, xfer_busy);
      end
      xfer_ack = (c == 3);
      step();
    end
    xfer_ack = 1'b0;
    tmo_seen += int'(timeout_err);
    n_chk++;
    if (sm_ps2 !== 3'd0 || tmo_seen != 0) begin
      n_fail++;
      $display("FAIL xfer_done got ps2=%0d tmo=%0d exp 0/0",
               sm_ps2, tmo_seen);
    end
  endtask

  task automatic test_back_to_back();
    xfer_req = 1'b1;
    step();
    xfer_req = 1'b0;
    n_chk++;
    if (sm_ps2 !== 3'd1) begin
      n_fail++;
      $display("FAIL b2b_enter got %0d exp 1", sm_ps2);
    end
    xfer_ack = 1'b1;
    step();
    xfer_ack = 1'b0;
    n_chk++;
    if (sm_ps2 !== 3'd0 || err_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL b2b_exit got ps2=%0d err=%0d exp 0/0",
               sm_ps2, err_cnt);
    end
  endtask

  task automatic test_timeout();
    int busy = 0;
    goto_zot();
    xfer_req = 1'b1;
    step();
    xfer_req = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      busy += int'(xfer_busy);
      step();
    end
    n_chk++;
    if (busy != 15) begin
      n_fail++;
      $display("FAIL tmo_len got %0d exp 15", busy);
    end
    n_chk++;
    if (sm_ps2 !== 3'd0 || timeout_err !== 1'b1 ||
        err_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL tmo_hit got ps2=%0d tmo=%b err=%0d exp 0/1/1",
               sm_ps2, timeout_err, err_cnt);
    end
    step();
    n_chk++;
    if (timeout_err !== 1'b0 || err_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL tmo_pulse got tmo=%b err=%0d exp 0/1",
               timeout_err, err_cnt);
    end
  endtask

  task automatic test_saturate();
    int pulses = 0;
    for (int k = 0; k < 259; k++) begin
      xfer_req = 1'b1;
      step();
      xfer_req = 1'b0;
      repeat (15) step();
      pulses += int'(timeout_err);
      if (k == 253) begin
        n_chk++;
        if (err_cnt !== 8'd255) begin
          n_fail++;
          $display("FAIL sat_reach got %0d exp 255", err_cnt);
        end
      end
    end
    n_chk++;
    if (pulses != 259 || err_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL sat_final got pulses=%0d err=%0d exp 259/255",
               pulses, err_cnt);
    end
  endtask

  task automatic test_coincide();
    goto_zot();
    xfer_req = 1'b1;
    step();
    xfer_req = 1'b0;
    repeat (14) step();
    xfer_ack = 1'b1;
    step();
    xfer_ack = 1'b0;
    n_chk++;
    if (sm_ps2 !== 3'd0 || timeout_err !== 1'b0 ||
        err_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL coincide got ps2=%0d tmo=%b err=%0d exp 0/0/0",
               sm_ps2, timeout_err, err_cnt);
    end
  endtask

  task automatic test_deferred_stop();
    goto_zot();
    xfer_req = 1'b1;
    step();
    xfer_req = 1'b0;
    stop_req = 1'b1;
    step();
    stop_req = 1'b0;
    xfer_req = 1'b1;
    n_chk++;
    if (sm_psm !== 3'd7 || sm_ps2 !== 3'd1) begin
      n_fail++;
      $display("FAIL dstop_hold got %0d/%0d exp 7/1", sm_psm, sm_ps2);
    end
    step();
    xfer_ack = 1'b1;
    step();
    xfer_ack = 1'b0;
    n_chk++;
    if (sm_psm !== 3'd7 || sm_ps2 !== 3'd0) begin
      n_fail++;
      $display("FAIL dstop_drain got %0d/%0d exp 7/0", sm_psm, sm_ps2);
    end
    step();
    n_chk++;
    if (sm_psm !== 3'd0 || sm_ps2 !== 3'd0) begin
      n_fail++;
      $display("FAIL dstop_idle got %0d/%0d exp 0/0", sm_psm, sm_ps2);
    end
    step();
    xfer_req = 1'b0;
    n_chk++;
    if (sm_ps2 !== 3'd0) begin
      n_fail++;
      $display("FAIL dstop_noxfer got %0d exp 0", sm_ps2);
    end
  endtask

  task automatic test_abort();
    reset = 1'b1;
    step();
    reset = 1'b0;
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    step();
    stop_req = 1'b1;
    step();
    stop_req = 1'b0;
    n_chk++;
    if (sm_psm !== 3'd0 || rst_out !== 1'b0) begin
      n_fail++;
      $display("FAIL abort got psm=%0d rst=%b exp 0/0", sm_psm, rst_out);
    end
  endtask

  task automatic test_reset_mid();
    goto_zot();
    xfer_req = 1'b1;
    step();
    repeat (13) step();
    reset = 1'b1;
    start_req = 1'b1;
    stop_req = 1'b1;
    step();
    reset = 1'b0;
    start_req = 1'b0;
    stop_req = 1'b0;
    xfer_req = 1'b0;
    n_chk++;
    if (sm_psm !== 3'd0 || sm_ps2 !== 3'd0 || rst_out !== 1'b0 ||
        xfer_busy !== 1'b0 || timeout_err !== 1'b0 ||
        err_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_mid got %0d/%0d/%b/%b/%b/%0d exp all 0",
               sm_psm, sm_ps2, rst_out, xfer_busy, timeout_err,
               err_cnt);
    end
    step();
    n_chk++;
    if (timeout_err !== 1'b0 || err_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_mid_tmo got %b/%0d exp 0/0",
               timeout_err, err_cnt);
    end
  endtask

  initial begin
    reset = 1'b1;
    start_req = 1'b0;
    stop_req = 1'b0;
    xfer_req = 1'b0;
    xfer_ack = 1'b0;
    test_reset();
    test_sequence();
    test_transfer();
    test_back_to_back();
    test_timeout();
    test_saturate();
    test_coincide();
    test_deferred_stop();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
